// File: rtl/pr_fetch_ctrl.sv
// rtl/pr_fetch_ctrl.sv - PageRank stream fetch sequencer with credit-based line buffer flow control
module pr_fetch_ctrl #(
    parameter int FULL_WIDTH = 512,
    parameter int WIDTH      = 64,
    parameter int LOG_DEPTH  = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_line,
    input  logic [CNT_W-1:0]      elem_count,
    output logic                  busy,
    output logic                  done,
    output logic                  req_valid,
    output logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_ready,
    input  logic                  resp_valid,
    input  logic [FULL_WIDTH-1:0] resp_data,
    output logic                  buf_wrreq,
    output logic [FULL_WIDTH-1:0] buf_wdata,
    output logic                  buf_last,
    output logic [7:0]            buf_bounds,
    input  logic                  line_freed
);
    localparam int ELEMS     = FULL_WIDTH / WIDTH;
    localparam int LOG_ELEMS = $clog2(ELEMS);
    localparam int CREDITS   = 1 << LOG_DEPTH;
    localparam int CR_W      = LOG_DEPTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CR_W-1:0]       credits_q, credits_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [CNT_W-1:0]      returned_q, returned_d;
    logic [CNT_W-1:0]      total_q, total_d;
    logic [7:0]            bounds_q, bounds_d;
    logic                  done_q, done_d;
    logic                  req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
    logic                  wrreq_q, wrreq_d;
    logic [FULL_WIDTH-1:0] wdata_q, wdata_d;
    logic                  last_q, last_d;
    logic [7:0]            wbounds_q, wbounds_d;

    logic                  hs;
    logic                  resp_acc;
    logic [CNT_W-1:0]      issued_inc;
    logic [CNT_W-1:0]      returned_inc;
    logic [CNT_W-1:0]      rem_cnt;
    logic [CNT_W-1:0]      start_lines;
    logic [7:0]            start_bounds;

    assign hs           = req_valid_q & req_ready;
    assign resp_acc     = resp_valid & (state_q != IDLE);
    assign issued_inc   = issued_q + CNT_W'(hs);
    assign returned_inc = returned_q + CNT_W'(1);
    // Remainder-based ceil avoids overflow of elem_count + ELEMS - 1.
    assign rem_cnt      = elem_count & CNT_W'(ELEMS - 1);
    assign start_lines  = (elem_count >> LOG_ELEMS) + CNT_W'(rem_cnt != '0);
    assign start_bounds = (rem_cnt == '0) ? 8'(ELEMS) : rem_cnt[7:0];

    always_comb begin
        credits_d = credits_q;
        if (hs && !line_freed) begin
            credits_d = credits_q - CR_W'(1);
        end else if (!hs && line_freed && credits_q != CR_W'(CREDITS)) begin
            credits_d = credits_q + CR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && elem_count != '0) state_d = ISSUE;
            ISSUE:   if (issued_inc == total_q) state_d = DRAIN;
            DRAIN:   if (returned_q == total_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issued_d    = issued_q;
        returned_d  = returned_q;
        total_d     = total_q;
        bounds_d    = bounds_q;
        done_d      = 1'b0;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        wrreq_d     = 1'b0;
        wdata_d     = wdata_q;
        last_d      = last_q;
        wbounds_d   = wbounds_q;
        case (state_q)
            IDLE: begin
                req_valid_d = 1'b0;
                if (start && elem_count == '0) begin
                    done_d = 1'b1;
                end else if (start) begin
                    total_d     = start_lines;
                    bounds_d    = start_bounds;
                    issued_d    = '0;
                    returned_d  = '0;
                    req_addr_d  = base_line;
                    req_valid_d = (credits_d != '0);
                end
            end
            ISSUE: begin
                // Next request is decided from post-handshake counts so it can follow back to back.
                issued_d    = issued_inc;
                req_addr_d  = req_addr_q + ADDR_W'(hs);
                req_valid_d = (issued_inc < total_q) && (credits_d != '0);
            end
            DRAIN: begin
                req_valid_d = 1'b0;
                if (returned_q == total_q) done_d = 1'b1;
            end
            default: req_valid_d = 1'b0;
        endcase
        if (resp_acc) begin
            returned_d = returned_inc;
            wrreq_d    = 1'b1;
            wdata_d    = resp_data;
            last_d     = (returned_inc == total_q);
            wbounds_d  = (returned_inc == total_q) ? bounds_q : 8'(ELEMS);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_q   <= CR_W'(CREDITS);
            issued_q    <= '0;
            returned_q  <= '0;
            total_q     <= '0;
            bounds_q    <= '0;
            done_q      <= 1'b0;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            wrreq_q     <= 1'b0;
            wdata_q     <= '0;
            last_q      <= 1'b0;
            wbounds_q   <= '0;
        end else begin
            credits_q   <= credits_d;
            issued_q    <= issued_d;
            returned_q  <= returned_d;
            total_q     <= total_d;
            bounds_q    <= bounds_d;
            done_q      <= done_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            wrreq_q     <= wrreq_d;
            wdata_q     <= wdata_d;
            last_q      <= last_d;
            wbounds_q   <= wbounds_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign req_valid  = req_valid_q;
    assign req_addr   = req_addr_q;
    assign buf_wrreq  = wrreq_q;
    assign buf_wdata  = wdata_q;
    assign buf_last   = last_q;
    assign buf_bounds = wbounds_q;
endmodule

// File: tb/tb_pr_fetch_ctrl.sv
// tb/tb_pr_fetch_ctrl.sv - directed bench for pr_fetch_ctrl with a single-cycle memory model
module tb_pr_fetch_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_line = '0;
    logic [15:0]  elem_count = '0;
    logic         busy, done, req_valid, buf_wrreq, buf_last;
    logic [31:0]  req_addr;
    logic         req_ready = 1'b1;
    logic         resp_valid = 1'b0;
    logic [511:0] resp_data = '0;
    logic [511:0] buf_wdata;
    logic [7:0]   buf_bounds;
    logic         line_freed = 1'b0;

    always #5 clk = ~clk;

    pr_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_line(base_line),
        .elem_count(elem_count), .busy(busy), .done(done), .req_valid(req_valid),
        .req_addr(req_addr), .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_data(resp_data), .buf_wrreq(buf_wrreq), .buf_wdata(buf_wdata),
        .buf_last(buf_last), .buf_bounds(buf_bounds), .line_freed(line_freed)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_wr_cyc = 0;
    bit busy_at_done = 1'b0;
    bit mem_en = 1'b1;
    logic [31:0]  req_log[$];
    logic [511:0] wr_data[$];
    logic         wr_last[$];
    logic [7:0]   wr_bounds[$];

    task automatic clear_logs();
        req_log.delete(); wr_data.delete(); wr_last.delete(); wr_bounds.delete();
        done_cnt = 0;
    endtask

    // One clock: log the handshake about to happen, then model memory and record buffer writes.
    task automatic cycle();
        logic        hs_now;
        logic [31:0] addr_now;
        hs_now = req_valid && req_ready;
        addr_now = req_addr;
        if (hs_now) req_log.push_back(addr_now);
        @(posedge clk);
        #1;
        cyc++;
        if (mem_en) begin
            resp_valid = hs_now;
            resp_data = {16{addr_now}};
        end
        if (buf_wrreq) begin
            wr_data.push_back(buf_wdata); wr_last.push_back(buf_last); wr_bounds.push_back(buf_bounds);
            last_wr_cyc = cyc;
        end
        if (done) begin
            done_cnt++; done_cyc = cyc; busy_at_done = busy;
        end
    endtask

    task automatic run_until_done(input int budget, output bit ok);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            cycle();
            k++;
        end
        ok = (done_cnt != 0);
    endtask

    task automatic free_lines(input int n);
        line_freed = 1'b1;
        repeat (n) cycle();
        line_freed = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({busy, done, req_valid, buf_wrreq, buf_last} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, req_valid, buf_wrreq, buf_last});
        end
        n_checks++;
        if (req_addr !== 32'h0 || buf_bounds !== 8'h0) begin
            n_fail++; $display("FAIL reset_addr_bounds: got %h/%h expected 0/0", req_addr, buf_bounds);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        bit ok;
        logic [511:0] exp_d;
        clear_logs();
        base_line = 32'h100; elem_count = 16'd20; start = 1'b1;
        cycle();
        start = 1'b0;
        n_checks++;
        if ({busy, req_valid} !== 2'b11 || req_addr !== 32'h100) begin
            n_fail++; $display("FAIL basic_start: got busy/valid %b addr %h expected 11 100", {busy, req_valid}, req_addr);
        end
        run_until_done(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout: got no done expected done"); end
        n_checks++;
        if (req_log.size() != 3) begin n_fail++; $display("FAIL basic_req_count: got %0d expected 3", req_log.size()); end
        for (int i = 0; i < req_log.size() && i < 3; i++) begin
            n_checks++;
            if (req_log[i] !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL basic_req_addr%0d: got %h expected %h", i, req_log[i], 32'h100 + 32'(i));
            end
        end
        n_checks++;
        if (wr_data.size() != 3) begin n_fail++; $display("FAIL basic_wr_count: got %0d expected 3", wr_data.size()); end
        for (int i = 0; i < wr_data.size() && i < 3; i++) begin
            exp_d = {16{32'h100 + 32'(i)}};
            n_checks++;
            if (wr_data[i] !== exp_d || wr_last[i] !== (i == 2) || wr_bounds[i] !== ((i == 2) ? 8'd4 : 8'd8)) begin
                n_fail++; $display("FAIL basic_wr%0d: got data %h last %b bounds %0d expected %h %b %0d", i,
                    wr_data[i][31:0], wr_last[i], wr_bounds[i], exp_d[31:0], (i == 2), (i == 2) ? 4 : 8);
            end
        end
        n_checks++;
        if (done_cyc != last_wr_cyc + 1 || busy_at_done !== 1'b0) begin
            n_fail++; $display("FAIL basic_done_timing: got done-last %0d busy %b expected 1 0", done_cyc - last_wr_cyc, busy_at_done);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        base_line = 32'h200; elem_count = 16'd16; start = 1'b1;
        cycle();
        start = 1'b0;
        n_checks++;
        if ({busy, req_valid, done} !== 3'b110 || req_addr !== 32'h200) begin
            n_fail++; $display("FAIL b2b_start: got busy/valid/done %b addr %h expected 110 200", {busy, req_valid, done}, req_addr);
        end
        run_until_done(50, ok);
        n_checks++;
        if (!ok || req_log.size() != 2 || wr_data.size() != 2) begin
            n_fail++; $display("FAIL b2b_counts: got done %b req %0d wr %0d expected 1 2 2", ok, req_log.size(), wr_data.size());
        end else begin
            n_checks++;
            if (wr_last[0] !== 1'b0 || wr_last[1] !== 1'b1 || wr_bounds[1] !== 8'd8 || req_log[1] !== 32'h201) begin
                n_fail++; $display("FAIL b2b_last: got last %b%b bounds %0d addr %h expected 01 8 201",
                    wr_last[0], wr_last[1], wr_bounds[1], req_log[1]);
            end
        end
    endtask

    task automatic test_zero();
        clear_logs();
        elem_count = 16'd0; start = 1'b1;
        cycle();
        start = 1'b0;
        n_checks++;
        if ({done, busy, req_valid} !== 3'b100) begin
            n_fail++; $display("FAIL zero_done: got done/busy/valid %b expected 100", {done, busy, req_valid});
        end
        cycle();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse: got done %b expected 0", done); end
        repeat (3) cycle();
        n_checks++;
        if (req_log.size() != 0 || wr_data.size() != 0 || done_cnt != 1) begin
            n_fail++; $display("FAIL zero_activity: got req %0d wr %0d done %0d expected 0 0 1", req_log.size(), wr_data.size(), done_cnt);
        end
    endtask

    task automatic test_credits();
        bit ok;
        free_lines(16);
        clear_logs();
        base_line = 32'h1000; elem_count = 16'd200; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (30) cycle();
        n_checks++;
        if (req_log.size() != 16 || req_valid !== 1'b0 || wr_data.size() != 16) begin
            n_fail++; $display("FAIL credit_stall: got req %0d valid %b wr %0d expected 16 0 16", req_log.size(), req_valid, wr_data.size());
        end
        line_freed = 1'b1;
        cycle();
        line_freed = 1'b0;
        n_checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h1010) begin
            n_fail++; $display("FAIL credit_release: got valid %b addr %h expected 1 1010", req_valid, req_addr);
        end
        repeat (3) cycle();
        n_checks++;
        if (req_log.size() != 17 || req_valid !== 1'b0) begin
            n_fail++; $display("FAIL credit_one: got req %0d valid %b expected 17 0", req_log.size(), req_valid);
        end
        line_freed = 1'b1;
        cycle();
        cycle();
        line_freed = 1'b0;
        n_checks++;
        if (req_valid !== 1'b1) begin n_fail++; $display("FAIL credit_simul: got valid %b expected 1", req_valid); end
        repeat (3) cycle();
        n_checks++;
        if (req_log.size() != 19 || req_valid !== 1'b0) begin
            n_fail++; $display("FAIL credit_simul_count: got req %0d valid %b expected 19 0", req_log.size(), req_valid);
        end
        free_lines(8);
        run_until_done(50, ok);
        n_checks++;
        if (!ok || req_log.size() != 25 || wr_data.size() != 25) begin
            n_fail++; $display("FAIL credit_finish: got done %b req %0d wr %0d expected 1 25 25", ok, req_log.size(), wr_data.size());
        end else begin
            n_checks++;
            if (req_log[24] !== 32'h1018 || wr_last[23] !== 1'b0 || wr_last[24] !== 1'b1 || wr_bounds[24] !== 8'd8) begin
                n_fail++; $display("FAIL credit_tail: got addr %h last %b%b bounds %0d expected 1018 01 8",
                    req_log[24], wr_last[23], wr_last[24], wr_bounds[24]);
            end
        end
    endtask

    task automatic test_random_ready();
        bit          stall;
        logic [31:0] held;
        int          k = 0;
        free_lines(16);
        clear_logs();
        base_line = 32'h300; elem_count = 16'd80; start = 1'b1;
        cycle();
        start = 1'b0;
        while (done_cnt == 0 && k < 200) begin
            req_ready = 1'($urandom_range(0, 1));
            stall = req_valid && !req_ready;
            held = req_addr;
            cycle();
            k++;
            if (stall) begin
                n_checks++;
                if (req_valid !== 1'b1 || req_addr !== held) begin
                    n_fail++; $display("FAIL rand_hold: got valid %b addr %h expected 1 %h", req_valid, req_addr, held);
                end
            end
        end
        req_ready = 1'b1;
        n_checks++;
        if (done_cnt == 0 || req_log.size() != 10 || wr_data.size() != 10) begin
            n_fail++; $display("FAIL rand_counts: got done %0d req %0d wr %0d expected 1 10 10", done_cnt, req_log.size(), wr_data.size());
        end
        for (int i = 0; i < req_log.size() && i < 10; i++) begin
            n_checks++;
            if (req_log[i] !== 32'h300 + 32'(i) || (i < wr_data.size() && wr_data[i][31:0] !== 32'h300 + 32'(i))) begin
                n_fail++; $display("FAIL rand_order%0d: got req %h expected %h", i, req_log[i], 32'h300 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k = 0;
        free_lines(16);
        clear_logs();
        base_line = 32'h400; elem_count = 16'd40; start = 1'b1;
        cycle();
        start = 1'b0;
        while (req_log.size() < 2 && k < 10) begin
            cycle();
            k++;
        end
        req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, req_valid, buf_wrreq, buf_last} !== 5'b0 || req_addr !== 32'h0 || buf_bounds !== 8'h0) begin
            n_fail++; $display("FAIL midreset_async: got flags %b addr %h bounds %h expected 00000 0 0",
                {busy, done, req_valid, buf_wrreq, buf_last}, req_addr, buf_bounds);
        end
        cycle();
        rst_n = 1'b1;
        mem_en = 1'b0;
        resp_valid = 1'b1;
        resp_data = {16{32'hdead_0402}};
        cycle();
        n_checks++;
        if (buf_wrreq !== 1'b0) begin n_fail++; $display("FAIL midreset_drop1: got wrreq %b expected 0", buf_wrreq); end
        cycle();
        n_checks++;
        if (buf_wrreq !== 1'b0) begin n_fail++; $display("FAIL midreset_drop2: got wrreq %b expected 0", buf_wrreq); end
        resp_valid = 1'b0;
        mem_en = 1'b1;
        req_ready = 1'b1;
        clear_logs();
        base_line = 32'h500; elem_count = 16'd128; start = 1'b1;
        cycle();
        start = 1'b0;
        run_until_done(80, ok);
        n_checks++;
        if (!ok || req_log.size() != 16 || wr_data.size() != 16) begin
            n_fail++; $display("FAIL midreset_restart: got done %b req %0d wr %0d expected 1 16 16", ok, req_log.size(), wr_data.size());
        end else begin
            n_checks++;
            if (req_log[0] !== 32'h500 || req_log[15] !== 32'h50f || wr_last[15] !== 1'b1 || wr_bounds[15] !== 8'd8) begin
                n_fail++; $display("FAIL midreset_tail: got %h..%h last %b bounds %0d expected 500..50f 1 8",
                    req_log[0], req_log[15], wr_last[15], wr_bounds[15]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero();
        test_credits();
        test_random_ready();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pr_fetch_ctrl.md
# pr_fetch_ctrl

Fetch sequencer for one PageRank read stream: given a starting line address and an element count, it issues line reads to memory, forwards returned lines into the stream's line buffer with correct end-of-stream bounds, and never over-commits buffer space. Sits between the memory read port and the per-stream line buffer. The buffer's consumer returns space to the sequencer one line at a time.

## Interface
- FULL_WIDTH, 512: line width in bits.
- WIDTH, 64: element width in bits; ELEMS = FULL_WIDTH/WIDTH, a power of two, at most 128.
- LOG_DEPTH, 4: log2 of buffer depth in lines; CREDITS = 1<<LOG_DEPTH.
- ADDR_W, 32: line address width.
- CNT_W, 16: element count width.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- base_line  in  ADDR_W  first line address.
- elem_count  in  CNT_W  number of elements to fetch.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- req_valid  out  1  memory read request valid.
- req_addr  out  ADDR_W  line address of the request.
- req_ready  in  1  memory accepts the request when valid and ready are both high.
- resp_valid  in  1  read data returned, in request order, always accepted.
- resp_data  in  FULL_WIDTH  returned line.
- buf_wrreq  out  1  write strobe to the line buffer.
- buf_wdata  out  FULL_WIDTH  line to the buffer.
- buf_last  out  1  marks the final line of the stream.
- buf_bounds  out  8  valid elements in the final line.
- line_freed  in  1  one-cycle pulse when the consumer drains a buffer line.

## Operation
- total_lines = ceil(elem_count/ELEMS). last_bounds = elem_count mod ELEMS, or ELEMS when the remainder is 0. Both are computed at start in CNT_W arithmetic. Addresses wrap modulo 2^ADDR_W.
- The FSM has states IDLE, ISSUE, DRAIN.
- IDLE:
  - start with elem_count==0 produces a done pulse on the next cycle, with no requests and busy staying low.
  - start with a nonzero count latches base_line, total_lines and last_bounds, and moves to ISSUE.
- ISSUE:
  - req_valid is asserted when issued<total_lines and credits>0.
  - On each handshake: req_addr advances by 1, issued increments, credits decrements.
  - When issued reaches total_lines, the FSM moves to DRAIN.
- DRAIN:
  - Waits until returned==total_lines.
  - Then pulses done and returns to IDLE.
- Credits:
  - credits resets to CREDITS.
  - A handshake decrements it and line_freed increments it. Both in the same cycle leave it unchanged.
  - credits never exceeds CREDITS. A line_freed arriving at the maximum is ignored.
  - credits persists across commands, because lines from a finished stream may still be in the buffer.
- Responses:
  - Each resp_valid increments returned and is forwarded to the buffer.
  - buf_last=1 and buf_bounds=last_bounds on the response that brings returned to total_lines. Otherwise buf_last=0 and buf_bounds=ELEMS.
  - A resp_valid while in IDLE is dropped, with no buf_wrreq.
- req_valid, once raised, holds with a stable req_addr until the handshake completes.
- start while busy is ignored.

## Timing
- Reset values, all asynchronous:
  - State and counters: state=IDLE, credits=CREDITS, issued=0, returned=0.
  - Outputs: busy=0, done=0, req_valid=0, req_addr=0, buf_wrreq=0, buf_last=0, buf_bounds=0.
- Reset asserted mid-stream aborts immediately. Later responses are dropped.
- start at cycle t gives busy=1 and req_valid=1 at t+1, provided credits>0.
- Issue throughput is one request per cycle while req_ready=1 and credits remain.
- The request path is registered: after a handshake at t, the next request is presented at t+1.
- resp_valid at t gives buf_wrreq at t+1, with buf_wdata, buf_last and buf_bounds registered. Latency is one cycle, throughput is one line per cycle.
- The final response at t gives buf_wrreq with buf_last at t+1, then done at t+2 with busy falling on the same edge.
- A new start is accepted in the cycle after done.

## Test plan
- ELEMS=8, base_line=0x100, elem_count=20, req_ready=1, single-cycle memory:
  - Expect requests to 0x100, 0x101, 0x102 and three buf_wrreq.
  - The third carries buf_last=1, buf_bounds=4.
  - Then one done pulse.
- elem_count=16: 2 lines, and the last has buf_bounds=8.
- elem_count=0: done one cycle after start, no req_valid, no buf_wrreq.
- CREDITS=16, elem_count=200 (25 lines), line_freed held low:
  - Exactly 16 requests issue, then req_valid stays low.
  - Each later line_freed pulse releases one more request.
  - A simultaneous handshake and line_freed keeps credits constant.
- req_ready toggled randomly: req_addr is stable while req_valid=1 && !req_ready, and there are no gaps or duplicate addresses.
- rst_n pulsed low after 2 of 5 requests:
  - All outputs reach reset values without a clock edge.
  - Late resp_valid produces no buf_wrreq.
  - A new start then runs cleanly with credits=CREDITS.
